synaptic_integrator: RTL and testbench

SYNAPTIC_INTEGRATOR -- requirements
Module: synaptic_integrator

---
 rtl/synaptic_integrator.sv | 115 +++++++++++
 tb/tb_synaptic_integrator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/synaptic_integrator.sv
// Sparse synaptic current integrator: one (pre,post) weight per cycle, saturating per post-neuron sums.
// Pass takes N*N+1 edges from accepted start to done; start is ignored while busy or in DONE, never queued.
module synaptic_integrator #(
    parameter int N  = 7,
    parameter int WW = 16,
    parameter int AW = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [N-1:0]        spikes,
    input  logic [N*N*WW-1:0]   weights_flat,
    output logic                busy,
    output logic                done,
    output logic [N*AW-1:0]     currents_flat
);

    localparam int IW = $clog2(N);
    localparam int SW = ((WW > AW) ? WW : AW) + 1;
    localparam logic signed [SW-1:0] MAXV = {{(SW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-AW+1){1'b1}}, {(AW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                state_q;
    logic [N-1:0]          spk_q;
    logic signed [AW-1:0]  acc_q [N];
    logic [IW-1:0]         i_q;
    logic [IW-1:0]         j_q;
    logic                  last_q;
    logic [N*AW-1:0]       cur_q;
    logic                  busy_q;
    logic                  done_q;

    logic signed [WW-1:0]  w_sel_d;
    logic signed [SW-1:0]  sum_d;
    logic signed [AW-1:0]  sat_d;
    logic                  hit_d;

    // Sum is formed wider than both operands so the clamp sees the true value.
    always_comb begin
        w_sel_d = weights_flat[(int'(i_q) * N + int'(j_q)) * WW +: WW];
        sum_d   = SW'(acc_q[j_q]) + SW'(w_sel_d);
        if (sum_d > MAXV)
            sat_d = MAXV[AW-1:0];
        else if (sum_d < MINV)
            sat_d = MINV[AW-1:0];
        else
            sat_d = sum_d[AW-1:0];
        hit_d = spk_q[i_q] && (i_q != j_q) && !last_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            spk_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            last_q  <= 1'b0;
            cur_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < N; k++) acc_q[k] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                        spk_q   <= spikes;
                        i_q     <= '0;
                        j_q     <= '0;
                        last_q  <= 1'b0;
                        for (int k = 0; k < N; k++) acc_q[k] <= '0;
                    end
                end
                SCAN: begin
                    // Final SCAN cycle only drains the last accumulate so currents load from settled registers.
                    if (last_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        for (int k = 0; k < N; k++) cur_q[k*AW +: AW] <= acc_q[k];
                    end else begin
                        if (hit_d) acc_q[j_q] <= sat_d;
                        if (i_q == IW'(N-1)) begin
                            i_q <= '0;
                            if (j_q == IW'(N-1))
                                last_q <= 1'b1;
                            else
                                j_q <= j_q + 1'b1;
                        end else begin
                            i_q <= i_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign currents_flat = cur_q;

endmodule

// File: tb/tb_synaptic_integrator.sv
// Directed bench for synaptic_integrator: a 16-bit instance for function and handshake, an 8-bit one for clamping.
module tb_synaptic_integrator;

    localparam int N = 7;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start_a, start_b;
    logic [N-1:0]      spikes_a, spikes_b;
    logic [N*N*16-1:0] w_a, w_b;
    logic              busy_a, busy_b, done_a, done_b;
    logic [N*16-1:0]   cur_a;
    logic [N*8-1:0]    cur_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    synaptic_integrator #(.N(N), .WW(16), .AW(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .spikes(spikes_a),
        .weights_flat(w_a), .busy(busy_a), .done(done_a), .currents_flat(cur_a)
    );

    synaptic_integrator #(.N(N), .WW(16), .AW(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .spikes(spikes_b),
        .weights_flat(w_b), .busy(busy_b), .done(done_b), .currents_flat(cur_b)
    );

    typedef struct {
        logic [N-1:0]    spk;
        int              w;
        bit              mode;   // 1: w[i][j] = w*(i+1)
        bit              drop;   // clear spikes right after the start edge
        logic [N*16-1:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [N*16-1:0] pk(input int e0, e1, e2, e3, e4, e5, e6);
        logic [N*16-1:0] r;
        r[0*16 +: 16] = 16'(e0); r[1*16 +: 16] = 16'(e1); r[2*16 +: 16] = 16'(e2);
        r[3*16 +: 16] = 16'(e3); r[4*16 +: 16] = 16'(e4); r[5*16 +: 16] = 16'(e5);
        r[6*16 +: 16] = 16'(e6);
        return r;
    endfunction

    function automatic logic [N*N*16-1:0] wgen(input int w, input bit mode);
        logic [N*N*16-1:0] r;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                r[(i*N+j)*16 +: 16] = 16'(mode ? w * (i + 1) : w);
        return r;
    endfunction

    function automatic int ia(input int k);
        logic signed [15:0] v;
        v = cur_a[k*16 +: 16];
        return int'(v);
    endfunction

    function automatic int ib(input int k);
        logic signed [7:0] v;
        v = cur_b[k*8 +: 8];
        return int'(v);
    endfunction

    // One full pass on instance sel; checks busy rise, 50-edge latency and a single-cycle done.
    task automatic run_pass(input bit sel, input bit drop, input string nm);
        int n;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        if (drop) spikes_a = '0;
        chk({nm, "_busy_rise"}, int'(sel ? busy_b : busy_a), 1);
        n = 0;
        while (n < 200) begin
            @(posedge clk); n++; #1;
            if (sel ? done_b : done_a) break;
        end
        chk({nm, "_latency"}, n, 50);
        @(posedge clk); #1;
        chk({nm, "_done_fall"}, int'(sel ? done_b : done_a), 0);
        chk({nm, "_busy_idle"}, int'(sel ? busy_b : busy_a), 0);
    endtask

    initial begin
        int dcnt, first, second, b51, b52;

        vecs[0] = '{7'b0000011, 1,      1'b0, 1'b0, pk(1, 1, 2, 2, 2, 2, 2)};
        vecs[1] = '{7'b0000001, 5,      1'b0, 1'b0, pk(0, 5, 5, 5, 5, 5, 5)};
        vecs[2] = '{7'b0000101, 1,      1'b1, 1'b0, pk(3, 4, 1, 4, 4, 4, 4)};
        vecs[3] = '{7'b1111111, -3,     1'b0, 1'b0, pk(-18, -18, -18, -18, -18, -18, -18)};
        vecs[4] = '{7'b1000000, 1000,   1'b0, 1'b0, pk(1000, 1000, 1000, 1000, 1000, 1000, 0)};
        vecs[5] = '{7'b1111111, 16000,  1'b0, 1'b0, pk(32767, 32767, 32767, 32767, 32767, 32767, 32767)};
        vecs[6] = '{7'b1111111, -16000, 1'b0, 1'b0, pk(-32768, -32768, -32768, -32768, -32768, -32768, -32768)};
        vecs[7] = '{7'b1111111, 2,      1'b0, 1'b1, pk(12, 12, 12, 12, 12, 12, 12)};

        reset_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        spikes_a = '0;  spikes_b = '0;
        w_a = '0;       w_b = '0;
        #12;
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_cur_zero", int'(cur_a == '0), 1);
        @(negedge clk); reset_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            spikes_a = vecs[v].spk;
            w_a      = wgen(vecs[v].w, vecs[v].mode);
            run_pass(1'b0, vecs[v].drop, $sformatf("v%0d", v));
            for (int k = 0; k < N; k++) begin
                logic signed [15:0] e;
                e = vecs[v].exp[k*16 +: 16];
                chk($sformatf("v%0d_I%0d", v, k), ia(k), int'(e));
            end
        end

        // AW=8 clamp in both directions.
        spikes_b = '1;
        w_b = wgen(100, 1'b0);
        run_pass(1'b1, 1'b0, "satpos");
        for (int k = 0; k < N; k++) chk($sformatf("satpos_I%0d", k), ib(k), 127);
        w_b = wgen(-100, 1'b0);
        run_pass(1'b1, 1'b0, "satneg");
        for (int k = 0; k < N; k++) chk($sformatf("satneg_I%0d", k), ib(k), -128);

        // Reset mid-scan aborts the pass and clears currents immediately.
        spikes_a = '1;
        w_a = wgen(1, 1'b0);
        start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        repeat (20) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy_a), 0);
        chk("midrst_done", int'(done_a), 0);
        chk("midrst_cur_zero", int'(cur_a == '0), 1);
        @(negedge clk); reset_n = 1'b1;
        dcnt = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (done_a) dcnt++;
        end
        chk("midrst_no_done", dcnt, 0);
        @(negedge clk);
        run_pass(1'b0, 1'b0, "postrst");
        for (int k = 0; k < N; k++) chk($sformatf("postrst_I%0d", k), ia(k), 6);

        // Start pulses during SCAN and DONE are dropped.
        spikes_a = 7'b0000011;
        start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        dcnt = 0; first = 0;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk); #1;
            if (done_a) begin
                dcnt++;
                if (first == 0) first = n;
            end
            start_a = (n == 10 || n == 50);
        end
        chk("hs_done_count", dcnt, 1);
        chk("hs_done_edge", first, 50);
        chk("hs_idle_after", int'(busy_a), 0);
        chk("hs_I2", ia(2), 2);

        // Held start: one IDLE cycle after DONE, then the next pass begins.
        start_a = 1'b1;
        @(posedge clk); #1;
        first = 0; second = 0; b51 = -1; b52 = -1;
        for (int n = 1; n <= 120; n++) begin
            @(posedge clk); #1;
            if (done_a) begin
                if (first == 0) first = n;
                else if (second == 0) second = n;
            end
            if (n == 51) b51 = int'(busy_a);
            if (n == 52) b52 = int'(busy_a);
            if (second != 0) start_a = 1'b0;
        end
        chk("held_first_done", first, 50);
        chk("held_busy_idle_gap", b51, 0);
        chk("held_busy_rise", b52, 1);
        chk("held_second_done", second, 102);
        chk("held_stops", int'(busy_a), 0);
        chk("held_I0", ia(0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
